vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; drives the monitor and paces the edge-detect pixel pipeline.

---
 rtl/vga_timing_pkg.sv | 42 ++++
 rtl/vga_timing_gen_sig_delay.sv | 40 ++++
 rtl/vga_timing_gen.sv | 146 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared mode constants, polarity codes and elaboration helpers for the VGA raster
// timing generator.
package vga_timing_pkg;

    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    localparam int MAX_DLY = 16;

    // One axis of a video mode, in line order: sync, back porch, active, front porch.
    typedef struct packed {
        int sync;
        int bp;
        int act;
        int fp;
    } axis_timing_t;

    localparam axis_timing_t SVGA_800X600_H = '{sync: 128, bp: 88, act: 800, fp: 40};
    localparam axis_timing_t SVGA_800X600_V = '{sync: 4,   bp: 23, act: 600, fp: 1};
    localparam axis_timing_t VGA_640X480_H  = '{sync: 96,  bp: 48, act: 640, fp: 16};
    localparam axis_timing_t VGA_640X480_V  = '{sync: 2,   bp: 33, act: 480, fp: 10};

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bus_t;

    // Bits needed to hold value-1, i.e. the width of a 0..value-1 counter.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result++;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// Enable-gated shift register used to realign sync/DE with downstream pipeline latency.
// DEPTH=0 degenerates to a straight wire.
module sig_delay #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_rst_val,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    if (DEPTH == 0) begin : g_bypass
        logic w_unused;
        assign w_unused = ^{clk, rst, i_en, i_rst_val};
        assign o_data   = i_data;
    end else begin : g_shift
        logic [W-1:0] r_stage [DEPTH];

        // NOTE: every stage is reset, not just the output, so the first DEPTH steps
        // after reset show idle levels rather than stale sync from the previous frame.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= i_rst_val;
                end
            end else if (i_en) begin
                r_stage[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_data = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, registered sync/DE/coordinates,
// line/frame pulses and a latency-matched copy of hs/vs/de.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CW     = 11,
    parameter int   H_SYNC = SVGA_800X600_H.sync,
    parameter int   H_BP   = SVGA_800X600_H.bp,
    parameter int   H_ACT  = SVGA_800X600_H.act,
    parameter int   H_FP   = SVGA_800X600_H.fp,
    parameter int   V_SYNC = SVGA_800X600_V.sync,
    parameter int   V_BP   = SVGA_800X600_V.bp,
    parameter int   V_ACT  = SVGA_800X600_V.act,
    parameter int   V_FP   = SVGA_800X600_V.fp,
    parameter logic HS_POL = POL_ACTIVE_LOW,
    parameter logic VS_POL = POL_ACTIVE_LOW,
    parameter int   DLY    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start,
    output logic          hs_d,
    output logic          vs_d,
    output logic          de_d
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;

    if (CW < 1 || CW > 30 ||
        H_SYNC < 1 || H_BP < 1 || H_ACT < 1 || H_FP < 1 ||
        V_SYNC < 1 || V_BP < 1 || V_ACT < 1 || V_FP < 1 ||
        clog2(H_TOTAL) > CW || clog2(V_TOTAL) > CW ||
        DLY < 0 || DLY > MAX_DLY) begin : g_bad_params
        $fatal(1, "vga_timing_gen: illegal timing parameter set");
    end

    localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYNC_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYNC_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_ACT_START = CW'(H_SYNC + H_BP);
    localparam logic [CW-1:0] V_ACT_START = CW'(V_SYNC + V_BP);
    localparam logic [CW-1:0] H_ACT_END   = CW'(H_SYNC + H_BP + H_ACT);
    localparam logic [CW-1:0] V_ACT_END   = CW'(V_SYNC + V_BP + V_ACT);

    logic [CW-1:0] r_hcount;
    logic [CW-1:0] r_vcount;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_act;
    logic          w_v_act;
    logic          w_de;
    sync_bus_t     w_sync_now;
    sync_bus_t     w_sync_idle;
    sync_bus_t     w_sync_dly;

    assign w_h_wrap = (r_hcount == H_LAST);
    assign w_v_wrap = (r_vcount == V_LAST);
    assign w_h_act  = (r_hcount >= H_ACT_START) && (r_hcount < H_ACT_END);
    assign w_v_act  = (r_vcount >= V_ACT_START) && (r_vcount < V_ACT_END);
    assign w_de     = w_h_act && w_v_act;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge counter values, which is what gives the decode its one-step latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_hcount <= '0;
                r_vcount <= w_v_wrap ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    // Registered decode of the current counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_hs          <= (r_hcount < H_SYNC_END) ? HS_POL : ~HS_POL;
            r_vs          <= (r_vcount < V_SYNC_END) ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_x           <= w_de ? r_hcount - H_ACT_START : '0;
            r_y           <= w_de ? r_vcount - V_ACT_START : '0;
            r_line_start  <= (r_hcount == '0);
            r_frame_start <= (r_hcount == '0) && (r_vcount == '0);
        end
    end

    assign w_sync_now  = '{hs: r_hs, vs: r_vs, de: r_de};
    assign w_sync_idle = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

    sig_delay #(
        .W     ($bits(sync_bus_t)),
        .DEPTH (DLY)
    ) u_sync_delay (
        .clk       (clk),
        .rst       (rst),
        .i_en      (en),
        .i_rst_val (w_sync_idle),
        .i_data    (w_sync_now),
        .o_data    (w_sync_dly)
    );

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign hs_d        = w_sync_dly.hs;
    assign vs_d        = w_sync_dly.vs;
    assign de_d        = w_sync_dly.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four generator instances (800x600 defaults, two tiny rasters with
// delay/polarity variants, 640x480) compared every cycle against a step-count model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        int   hsync; int hbp; int hact; int hfp;
        int   vsync; int vbp; int vact; int vfp;
        logic hpol;  logic vpol;
        int   dly;
    } tb_geom_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
    } dec_t;

    localparam tb_geom_t G0 = '{128, 88, 800, 40, 4, 23, 600, 1, 1'b0, 1'b0, 0};
    localparam tb_geom_t G1 = '{4, 3, 10, 2, 2, 2, 5, 1, 1'b0, 1'b0, 3};
    localparam tb_geom_t G2 = '{3, 2, 6, 1, 1, 3, 4, 2, 1'b1, 1'b1, 16};
    localparam tb_geom_t G3 = '{96, 48, 640, 16, 2, 33, 480, 10, 1'b1, 1'b1, 0};
    localparam tb_geom_t GEO [N] = '{G0, G1, G2, G3};

    logic        clk;
    logic        rst;
    logic        en;
    logic [10:0] hc [N];
    logic [10:0] vc [N];
    logic [10:0] xo [N];
    logic [10:0] yo [N];
    logic        hs [N];
    logic        vs [N];
    logic        de [N];
    logic        ls [N];
    logic        fs [N];
    logic        hsd [N];
    logic        vsd [N];
    logic        ded [N];
    logic [51:0] obs [N];

    int steps;
    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_def (
        .clk(clk), .rst(rst), .en(en), .hcount(hc[0]), .vcount(vc[0]), .hs(hs[0]), .vs(vs[0]),
        .de(de[0]), .x(xo[0]), .y(yo[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .hs_d(hsd[0]), .vs_d(vsd[0]), .de_d(ded[0]));

    vga_timing_gen #(
        .CW(11), .H_SYNC(G1.hsync), .H_BP(G1.hbp), .H_ACT(G1.hact), .H_FP(G1.hfp),
        .V_SYNC(G1.vsync), .V_BP(G1.vbp), .V_ACT(G1.vact), .V_FP(G1.vfp),
        .HS_POL(G1.hpol), .VS_POL(G1.vpol), .DLY(G1.dly)
    ) u_small (
        .clk(clk), .rst(rst), .en(en), .hcount(hc[1]), .vcount(vc[1]), .hs(hs[1]), .vs(vs[1]),
        .de(de[1]), .x(xo[1]), .y(yo[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .hs_d(hsd[1]), .vs_d(vsd[1]), .de_d(ded[1]));

    vga_timing_gen #(
        .CW(11), .H_SYNC(G2.hsync), .H_BP(G2.hbp), .H_ACT(G2.hact), .H_FP(G2.hfp),
        .V_SYNC(G2.vsync), .V_BP(G2.vbp), .V_ACT(G2.vact), .V_FP(G2.vfp),
        .HS_POL(G2.hpol), .VS_POL(G2.vpol), .DLY(G2.dly)
    ) u_pol (
        .clk(clk), .rst(rst), .en(en), .hcount(hc[2]), .vcount(vc[2]), .hs(hs[2]), .vs(vs[2]),
        .de(de[2]), .x(xo[2]), .y(yo[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .hs_d(hsd[2]), .vs_d(vsd[2]), .de_d(ded[2]));

    vga_timing_gen #(
        .CW(11), .H_SYNC(VGA_640X480_H.sync), .H_BP(VGA_640X480_H.bp),
        .H_ACT(VGA_640X480_H.act), .H_FP(VGA_640X480_H.fp),
        .V_SYNC(VGA_640X480_V.sync), .V_BP(VGA_640X480_V.bp),
        .V_ACT(VGA_640X480_V.act), .V_FP(VGA_640X480_V.fp),
        .HS_POL(POL_ACTIVE_HIGH), .VS_POL(POL_ACTIVE_HIGH), .DLY(0)
    ) u_vga (
        .clk(clk), .rst(rst), .en(en), .hcount(hc[3]), .vcount(vc[3]), .hs(hs[3]), .vs(vs[3]),
        .de(de[3]), .x(xo[3]), .y(yo[3]), .line_start(ls[3]), .frame_start(fs[3]),
        .hs_d(hsd[3]), .vs_d(vsd[3]), .de_d(ded[3]));

    for (genvar i = 0; i < N; i++) begin : g_obs
        assign obs[i] = {hc[i], vc[i], hs[i], vs[i], de[i], xo[i], yo[i], ls[i], fs[i],
                         hsd[i], vsd[i], ded[i]};
    end

    // What the raster decode reports for raster position number j (j<0: idle/reset levels).
    function automatic dec_t decode(input tb_geom_t g, input int j);
        dec_t d;
        int   ht, vt, h, v;
        bit   ha, va;
        d = '{hs: ~g.hpol, vs: ~g.vpol, de: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0};
        if (j < 0) return d;
        ht = g.hsync + g.hbp + g.hact + g.hfp;
        vt = g.vsync + g.vbp + g.vact + g.vfp;
        h  = j % ht;
        v  = (j / ht) % vt;
        ha = (h >= g.hsync + g.hbp) && (h < g.hsync + g.hbp + g.hact);
        va = (v >= g.vsync + g.vbp) && (v < g.vsync + g.vbp + g.vact);
        d.hs = (h < g.hsync) ? g.hpol : ~g.hpol;
        d.vs = (v < g.vsync) ? g.vpol : ~g.vpol;
        d.de = ha && va;
        d.x  = d.de ? 11'(h - (g.hsync + g.hbp)) : 11'd0;
        d.y  = d.de ? 11'(v - (g.vsync + g.vbp)) : 11'd0;
        d.ls = (h == 0);
        d.fs = (h == 0) && (v == 0);
        return d;
    endfunction

    // Expected output vector after k enabled steps since reset.
    function automatic logic [51:0] model(input tb_geom_t g, input int k);
        int   ht, vt;
        dec_t now, late;
        ht   = g.hsync + g.hbp + g.hact + g.hfp;
        vt   = g.vsync + g.vbp + g.vact + g.vfp;
        now  = decode(g, k - 1);
        late = decode(g, k - 1 - g.dly);
        return {11'(k % ht), 11'((k / ht) % vt), now.hs, now.vs, now.de, now.x, now.y,
                now.ls, now.fs, late.hs, late.vs, late.de};
    endfunction

    task automatic tick(input logic en_v);
        en = en_v;
        @(posedge clk);
        if (en_v && !rst) steps++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        steps = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick(1'b1);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (obs[i] !== model(GEO[i], 0)) begin
                n_fail++;
                $display("FAIL reset inst=%0d got=%h exp=%h", i, obs[i], model(GEO[i], 0));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        for (int c = 0; c < 1200; c++) begin
            tick(1'b1);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (obs[i] !== model(GEO[i], steps)) begin
                    n_fail++;
                    $display("FAIL free_run inst=%0d step=%0d got=%h exp=%h",
                             i, steps, obs[i], model(GEO[i], steps));
                end
            end
        end
    endtask

    task automatic test_enable_toggle();
        for (int c = 0; c < 1000; c++) begin
            tick(c < 400 ? logic'(c % 2 == 0) : logic'($urandom_range(0, 1)));
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (obs[i] !== model(GEO[i], steps)) begin
                    n_fail++;
                    $display("FAIL enable inst=%0d step=%0d en=%0b got=%h exp=%h",
                             i, steps, en, obs[i], model(GEO[i], steps));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        repeat (37) tick(1'b1);
        #2 rst = 1'b1;
        #1 steps = 0;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (obs[i] !== model(GEO[i], 0)) begin
                n_fail++;
                $display("FAIL async_reset inst=%0d got=%h exp=%h", i, obs[i], model(GEO[i], 0));
            end
        end
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (fs[i] !== 1'b1 || hc[i] !== 11'd1 || vc[i] !== 11'd0) begin
                n_fail++;
                $display("FAIL restart inst=%0d got fs=%0b hc=%0d vc=%0d exp fs=1 hc=1 vc=0",
                         i, fs[i], hc[i], vc[i]);
            end
        end
        for (int c = 0; c < 60; c++) begin
            tick(1'b1);
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (obs[i] !== model(GEO[i], steps)) begin
                    n_fail++;
                    $display("FAIL after_reset inst=%0d step=%0d got=%h exp=%h",
                             i, steps, obs[i], model(GEO[i], steps));
                end
            end
        end
    endtask

    task automatic test_delay();
        logic [2:0] got;
        logic [2:0] exp_v;
        apply_reset();
        for (int c = 0; c < 40; c++) begin
            tick(logic'($urandom_range(0, 3) != 0));
            for (int i = 1; i <= 2; i++) begin
                got   = {hsd[i], vsd[i], ded[i]};
                exp_v = model(GEO[i], steps) & 52'h7;
                n_checks++;
                if (got !== exp_v) begin
                    n_fail++;
                    $display("FAIL delay inst=%0d step=%0d got=%b exp=%b", i, steps, got, exp_v);
                end
            end
        end
    endtask

    task automatic test_default_frame();
        int de_seen;
        apply_reset();
        de_seen = 0;
        for (int c = 0; c < 28800; c++) begin
            tick(1'b1);
            if (de[0] === 1'b1) de_seen++;
            for (int i = 0; i < N; i++) begin
                n_checks++;
                if (obs[i] !== model(GEO[i], steps)) begin
                    n_fail++;
                    $display("FAIL default_frame inst=%0d step=%0d got=%h exp=%h",
                             i, steps, obs[i], model(GEO[i], steps));
                end
            end
        end
        // First active pixel of 800x600 sits at raster position 27*1056+216.
        n_checks++;
        if (de_seen != 28800 - (27 * 1056 + 216)) begin
            n_fail++;
            $display("FAIL first_de count got=%0d exp=%0d", de_seen, 28800 - (27 * 1056 + 216));
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        steps    = 0;
        n_checks = 0;
        n_fail   = 0;
        @(negedge clk);
        test_reset();
        test_free_run();
        test_enable_toggle();
        test_async_reset();
        test_delay();
        test_default_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
